// File: rtl/day_14_rr_arbiter_if.sv
// Handshake bundle between requesters/consumer and the round-robin arbiter.
// The slave modport is the arbiter side; the master modport is the side that
// raises requests, acknowledges grants and consumes the one-hot select.
interface day_14_rr_arbiter_if;
  logic [3:0] req_i;
  logic       ack_i;
  logic [3:0] gnt_o;
  logic       gnt_vld_o;
  logic [1:0] gnt_idx_o;

  modport master (
    output req_i,
    output ack_i,
    input  gnt_o,
    input  gnt_vld_o,
    input  gnt_idx_o
  );

  modport slave (
    input  req_i,
    input  ack_i,
    output gnt_o,
    output gnt_vld_o,
    output gnt_idx_o
  );
endinterface

// File: rtl/day_14_rr_arbiter.sv
// Round-robin arbiter for four requesters driving a one-hot 4:1 mux select.
// The grant is registered and held until the consumer acks or the holder
// withdraws. The winner is chosen by scanning upward from the slot after the
// last winner, so the previous holder always ends up with lowest priority and
// is only re-granted back-to-back when it is the sole requester.
module day_14_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  day_14_rr_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] r_state;
  logic [1:0] r_last_ptr;
  logic [3:0] r_gnt;
  logic       r_gnt_vld;
  logic [1:0] r_gnt_idx;

  logic [0:0] w_state_nxt;
  logic [1:0] w_ptr_nxt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] w_idx_nxt;
  logic       w_pick_vld;
  logic [1:0] w_pick_idx;
  logic       w_hold_req;
  logic       w_release;

  // Returns {found, index}: first set request scanning ptr+1 .. ptr+4 (mod 4).
  // Iterating from the farthest slot down lets the nearest hit overwrite.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + k[1:0];
      if (req[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Binary index to one-hot select.
  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Next-state logic: arbitrate from IDLE, hold or re-arbitrate from GRANT.
  always_comb begin
    {w_pick_vld, w_pick_idx} = rr_pick(bus.req_i, r_last_ptr);
    w_hold_req  = bus.req_i[r_gnt_idx];
    w_release   = (r_state == ST_GRANT) && (bus.ack_i || !w_hold_req);
    w_state_nxt = r_state;
    w_ptr_nxt   = r_last_ptr;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_gnt_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = to_onehot(w_pick_idx);
          w_idx_nxt   = w_pick_idx;
          w_ptr_nxt   = w_pick_idx;
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          if (w_pick_vld) begin
            w_state_nxt = ST_GRANT;
            w_gnt_nxt   = to_onehot(w_pick_idx);
            w_idx_nxt   = w_pick_idx;
            w_ptr_nxt   = w_pick_idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end else begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = r_gnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  // State and registered outputs; reset clears any live grant immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_last_ptr <= 2'd3;
      r_gnt      <= 4'b0000;
      r_gnt_vld  <= 1'b0;
      r_gnt_idx  <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_ptr <= w_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_vld  <= |w_gnt_nxt;
      r_gnt_idx  <= w_idx_nxt;
    end
  end

  assign bus.gnt_o     = r_gnt;
  assign bus.gnt_vld_o = r_gnt_vld;
  assign bus.gnt_idx_o = r_gnt_idx;

endmodule

// File: tb/tb_day_14_rr_arbiter.sv
// Bench for the round-robin arbiter: directed vector table, reset-mid-grant
// sequence, then randomized traffic against a queue-free reference model with
// a one-hot mux attached to the select.
module tb_day_14_rr_arbiter;

  logic clk;
  logic reset_n;

  day_14_rr_arbiter_if bus ();

  day_14_rr_arbiter #(.NUM_REQ(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mux data sources and the one-hot mux driven by the grant.
  logic [7:0] x_i [4];
  logic [7:0] mux_out;
  always_comb begin
    mux_out = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (bus.gnt_o[i]) mux_out = mux_out | x_i[i];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: holder (-1 = none), last winner, last reported index.
  int m_hold;
  int m_last;
  int m_idx;

  task automatic model_reset();
    m_hold = -1;
    m_last = 3;
    m_idx  = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic a);
    if (m_hold < 0 || a || !r[m_hold]) begin
      m_hold = -1;
      for (int k = 1; k <= 4; k++) begin
        if (m_hold < 0 && r[(m_last + k) % 4]) m_hold = (m_last + k) % 4;
      end
      if (m_hold >= 0) begin
        m_last = m_hold;
        m_idx  = m_hold;
      end
    end
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_hold >= 0) ? (4'b0001 << m_hold) : 4'b0000;
  endfunction

  // Apply one cycle of inputs (called just after a falling edge).
  task automatic step(input logic [3:0] r, input logic a);
    bus.req_i = r;
    bus.ack_i = a;
    for (int i = 0; i < 4; i++) x_i[i] = 8'($urandom);
    model_step(r, a);
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] idx;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic a,
                              input logic [3:0] g, input logic [1:0] i);
    vec_t v;
    v.req = r; v.ack = a; v.gnt = g; v.idx = i;
    return v;
  endfunction

  vec_t tbl [21];

  logic [3:0] r_cur;
  logic       a_cur;
  logic       prev_vld;
  logic [3:0] prev_gnt;
  logic       new_gnt;
  int         wait_cnt [4];

  initial begin
    // rotation, skip/wrap, hold, withdraw, idle ack, sole re-grant
    tbl[0]  = mk(4'hF,    1'b0, 4'b0001, 2'd0);
    tbl[1]  = mk(4'hF,    1'b1, 4'b0010, 2'd1);
    tbl[2]  = mk(4'hF,    1'b1, 4'b0100, 2'd2);
    tbl[3]  = mk(4'hF,    1'b1, 4'b1000, 2'd3);
    tbl[4]  = mk(4'hF,    1'b1, 4'b0001, 2'd0);
    tbl[5]  = mk(4'b0100, 1'b1, 4'b0100, 2'd2);
    tbl[6]  = mk(4'b0011, 1'b1, 4'b0001, 2'd0);
    tbl[7]  = mk(4'b0011, 1'b1, 4'b0010, 2'd1);
    tbl[8]  = mk(4'b1110, 1'b0, 4'b0010, 2'd1);
    tbl[9]  = mk(4'b1110, 1'b0, 4'b0010, 2'd1);
    tbl[10] = mk(4'b1110, 1'b0, 4'b0010, 2'd1);
    tbl[11] = mk(4'b1110, 1'b0, 4'b0010, 2'd1);
    tbl[12] = mk(4'b1110, 1'b0, 4'b0010, 2'd1);
    tbl[13] = mk(4'b1110, 1'b1, 4'b0100, 2'd2);
    tbl[14] = mk(4'b0000, 1'b0, 4'b0000, 2'd2);
    tbl[15] = mk(4'b0100, 1'b0, 4'b0100, 2'd2);
    tbl[16] = mk(4'b0000, 1'b1, 4'b0000, 2'd2);
    tbl[17] = mk(4'b0000, 1'b1, 4'b0000, 2'd2);
    tbl[18] = mk(4'b1000, 1'b1, 4'b1000, 2'd3);
    tbl[19] = mk(4'b1000, 1'b1, 4'b1000, 2'd3);
    tbl[20] = mk(4'b0000, 1'b0, 4'b0000, 2'd3);

    for (int i = 0; i < 4; i++) x_i[i] = 8'h00;
    reset_n   = 1'b0;
    bus.req_i = 4'h0;
    bus.ack_i = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_gnt", int'(bus.gnt_o), 0);
    check("reset_vld", int'(bus.gnt_vld_o), 0);
    check("reset_idx", int'(bus.gnt_idx_o), 0);
    reset_n = 1'b1;

    // Directed vector table
    for (int v = 0; v < 21; v++) begin
      step(tbl[v].req, tbl[v].ack);
      check($sformatf("vec%0d_gnt", v), int'(bus.gnt_o), int'(tbl[v].gnt));
      check($sformatf("vec%0d_idx", v), int'(bus.gnt_idx_o), int'(tbl[v].idx));
      check($sformatf("vec%0d_vld", v), int'(bus.gnt_vld_o), int'(|tbl[v].gnt));
    end

    // Reset asserted mid-grant clears outputs without a clock edge
    step(4'b0100, 1'b0);
    check("pre_rst_gnt", int'(bus.gnt_o), int'(4'b0100));
    reset_n = 1'b0;
    #1;
    check("async_rst_gnt", int'(bus.gnt_o), 0);
    check("async_rst_vld", int'(bus.gnt_vld_o), 0);
    check("async_rst_idx", int'(bus.gnt_idx_o), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(4'hF, 1'b0);
    check("post_rst_gnt", int'(bus.gnt_o), int'(4'b0001));
    step(4'hF, 1'b1);
    check("post_rst_next", int'(bus.gnt_o), int'(4'b0010));

    // Randomized traffic against the model
    r_cur    = 4'hF;
    prev_vld = bus.gnt_vld_o;
    prev_gnt = bus.gnt_o;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) r_cur = 4'($urandom_range(0, 15));
      a_cur = ($urandom_range(0, 2) == 0);
      step(r_cur, a_cur);
      check("rnd_gnt", int'(bus.gnt_o), int'(m_gnt()));
      check("rnd_idx", int'(bus.gnt_idx_o), m_idx);
      check("rnd_vld", int'(bus.gnt_vld_o), int'(m_hold >= 0));
      check("rnd_onehot0", int'($onehot0(bus.gnt_o)), 1);
      if (bus.gnt_vld_o) check("rnd_mux", int'(mux_out), int'(x_i[bus.gnt_idx_o]));
      new_gnt = bus.gnt_vld_o && (!prev_vld || a_cur || bus.gnt_o != prev_gnt);
      for (int i = 0; i < 4; i++) begin
        if (!r_cur[i] || (new_gnt && bus.gnt_o[i])) begin
          wait_cnt[i] = 0;
        end else if (new_gnt) begin
          wait_cnt[i] = wait_cnt[i] + 1;
          check($sformatf("starve_req%0d", i), int'(wait_cnt[i] > 3), 0);
        end
      end
      prev_vld = bus.gnt_vld_o;
      prev_gnt = bus.gnt_o;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
